// File: rtl/err_pkg.sv
// err_pkg: shared types and helpers for the IR error sequencer.
//   err_state_t : sequencer state encoding (IDLE, SETTLE, SAMPLE, DONE)
//   acc_width   : accumulator width for a given reading width and channel count
//   pair_term   : signed, binary-weighted contribution of one channel reading
package err_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } err_state_t;

    // One bit per pair weight on top of the reading, plus a sign bit.
    // The sum of all weighted magnitudes stays below 2^(dw + num_ch/2).
    function automatic int acc_width(input int dw, input int num_ch);
        return dw + (num_ch / 2) + 1;
    endfunction

    // Channel ch belongs to pair ch>>1 with weight 2^(ch>>1); even channels
    // are right sensors (add), odd channels are left sensors (subtract).
    function automatic longint pair_term(input int unsigned ch, input longint unsigned val);
        longint mag;
        mag = longint'(val << (ch >> 1));
        if ((ch & 32'd1) != 32'd0) begin
            return -mag;
        end else begin
            return mag;
        end
    endfunction

endpackage

// File: rtl/err_accum_seq_if.sv
// err_accum_seq_if: sensor-side and controller-side signals of the sequencer.
//   IR_vld  : start/restart a sweep           (master -> slave)
//   ir_in   : reading of the selected channel (master -> slave)
//   sel     : channel select to the sensor mux (slave -> master)
//   busy    : sequencer not idle               (slave -> master)
//   err     : signed saturated error           (slave -> master)
//   err_vld : one-cycle pulse when err updates (slave -> master)
interface err_accum_seq_if
    import err_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int DW     = 12,
    parameter int ERR_W  = 16
);
    localparam int SEL_W = $clog2(NUM_CH);

    logic                    IR_vld;
    logic [DW-1:0]           ir_in;
    logic [SEL_W-1:0]        sel;
    logic                    busy;
    logic signed [ERR_W-1:0] err;
    logic                    err_vld;

    modport master (
        output IR_vld, ir_in,
        input  sel, busy, err, err_vld
    );

    modport slave (
        input  IR_vld, ir_in,
        output sel, busy, err, err_vld
    );

endinterface

// File: rtl/err_sat.sv
// err_sat: combinational signed saturator.
//   in_i  : signed value, IN_W bits
//   out_o : in_i clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1], OUT_W bits
module err_sat
    import err_pkg::*;
#(
    parameter int IN_W  = 17,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  in_i,
    output logic signed [OUT_W-1:0] out_o
);

    if (IN_W <= OUT_W) begin : g_ext
        // Output is at least as wide as the input: plain sign extension.
        assign out_o = OUT_W'(in_i);
    end else begin : g_clamp
        localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
        localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

        // Clamp to the output range, otherwise drop the redundant sign bits.
        always_comb begin
            if (in_i > MAX_V) begin
                out_o = MAX_V[OUT_W-1:0];
            end else if (in_i < MIN_V) begin
                out_o = MIN_V[OUT_W-1:0];
            end else begin
                out_o = in_i[OUT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/err_accum_seq.sv
// err_accum_seq: walks an NUM_CH-channel IR sensor mux, waits SETTLE_CYC
// cycles per channel, accumulates a binary-weighted right-minus-left sum and
// presents it saturated to ERR_W bits with a one-cycle valid pulse.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : slave side of err_accum_seq_if (IR_vld, ir_in in; sel, busy, err, err_vld out)
module err_accum_seq
    import err_pkg::*;
#(
    parameter int NUM_CH     = 8,
    parameter int DW         = 12,
    parameter int ERR_W      = 16,
    parameter int SETTLE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    err_accum_seq_if.slave   bus
);

    localparam int CW  = $clog2(NUM_CH);
    localparam int AW  = acc_width(DW, NUM_CH);
    localparam int SCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [SCW-1:0] SETTLE_LAST = SCW'((SETTLE_CYC > 0) ? (SETTLE_CYC - 1) : 0);
    localparam logic [CW-1:0]  CH_LAST     = CW'(NUM_CH - 1);
    // With no settle time a sweep goes straight from one sample to the next.
    localparam err_state_t     START_ST    = (SETTLE_CYC == 0) ? ST_SAMPLE : ST_SETTLE;

    err_state_t              state_q, state_d;
    logic [CW-1:0]           ch_q, ch_d;
    logic [SCW-1:0]          settle_q, settle_d;
    logic signed [AW-1:0]    acc_q, acc_d;
    logic signed [ERR_W-1:0] err_q, err_d;

    logic signed [AW-1:0]    term_s;
    logic signed [AW-1:0]    acc_sum_s;
    logic signed [ERR_W-1:0] sat_s;

    assign term_s    = AW'(pair_term(32'(ch_q), 64'(bus.ir_in)));
    assign acc_sum_s = acc_q + term_s;

    err_sat #(
        .IN_W  (AW),
        .OUT_W (ERR_W)
    ) u_sat (
        .in_i  (acc_sum_s),
        .out_o (sat_s)
    );

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ch_q     <= '0;
            settle_q <= '0;
            acc_q    <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            settle_q <= settle_d;
            acc_q    <= acc_d;
            err_q    <= err_d;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        settle_d = settle_q;
        acc_d    = acc_q;
        err_d    = err_q;
        if (bus.IR_vld) begin
            // Start from IDLE or DONE, abort from SETTLE/SAMPLE: same action.
            state_d  = START_ST;
            ch_d     = '0;
            settle_d = '0;
            acc_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_d  = ST_SAMPLE;
                        settle_d = '0;
                    end else begin
                        settle_d = settle_q + SCW'(1);
                    end
                end
                ST_SAMPLE: begin
                    acc_d = acc_sum_s;
                    if (ch_q == CH_LAST) begin
                        // sel returns to 0 already here so it is 0 in IDLE.
                        state_d = ST_DONE;
                        ch_d    = '0;
                        err_d   = sat_s;
                    end else begin
                        state_d = START_ST;
                        ch_d    = ch_q + CW'(1);
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decoded from registers only.
    always_comb begin
        bus.busy    = (state_q != ST_IDLE);
        bus.err_vld = (state_q == ST_DONE);
        bus.sel     = ch_q;
        bus.err     = err_q;
    end

endmodule

// File: tb/tb_err_accum_seq.sv
// tb_err_accum_seq: self-checking bench for err_accum_seq.
// Three instances: defaults (A), ERR_W=12 (B), SETTLE_CYC=0 (C).
module tb_err_accum_seq;
    import err_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   ir_tab [3][8];
    int   held_err [3];

    always #5 clk = ~clk;

    err_accum_seq_if #(.NUM_CH(8), .DW(12), .ERR_W(16)) bus_a ();
    err_accum_seq_if #(.NUM_CH(8), .DW(12), .ERR_W(12)) bus_b ();
    err_accum_seq_if #(.NUM_CH(8), .DW(12), .ERR_W(16)) bus_c ();

    err_accum_seq #(.NUM_CH(8), .DW(12), .ERR_W(16), .SETTLE_CYC(2)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    err_accum_seq #(.NUM_CH(8), .DW(12), .ERR_W(12), .SETTLE_CYC(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
    err_accum_seq #(.NUM_CH(8), .DW(12), .ERR_W(16), .SETTLE_CYC(0)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

    // Reference: signed weighted right-minus-left sum, clamped to the output range.
    function automatic int model_err(input int id);
        int sum;
        int hi;
        sum = 0;
        for (int c = 0; c < 8; c++) begin
            if (c % 2 == 0) sum += ir_tab[id][c] * (2 ** (c / 2));
            else            sum -= ir_tab[id][c] * (2 ** (c / 2));
        end
        hi = (id == 1) ? 2047 : 32767;
        if (sum > hi) sum = hi;
        if (sum < -hi - 1) sum = -hi - 1;
        return sum;
    endfunction

    function automatic logic signed [31:0] get_err(input int id);
        case (id)
            0: return 32'($signed(bus_a.err));
            1: return 32'($signed(bus_b.err));
            default: return 32'($signed(bus_c.err));
        endcase
    endfunction

    function automatic logic [31:0] get_vld(input int id);
        case (id)
            0: return {31'd0, bus_a.err_vld};
            1: return {31'd0, bus_b.err_vld};
            default: return {31'd0, bus_c.err_vld};
        endcase
    endfunction

    function automatic logic [31:0] get_busy(input int id);
        case (id)
            0: return {31'd0, bus_a.busy};
            1: return {31'd0, bus_b.busy};
            default: return {31'd0, bus_c.busy};
        endcase
    endfunction

    function automatic logic [31:0] get_sel(input int id);
        case (id)
            0: return 32'(bus_a.sel);
            1: return 32'(bus_b.sel);
            default: return 32'(bus_c.sel);
        endcase
    endfunction

    task automatic set_vld(input int id, input logic v);
        case (id)
            0: bus_a.IR_vld = v;
            1: bus_b.IR_vld = v;
            default: bus_c.IR_vld = v;
        endcase
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one cycle; the sensor mux follows sel just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        bus_a.ir_in = 12'(ir_tab[0][bus_a.sel]);
        bus_b.ir_in = 12'(ir_tab[1][bus_b.sel]);
        bus_c.ir_in = 12'(ir_tab[2][bus_c.sel]);
    endtask

    task automatic clear_tab(input int id);
        for (int c = 0; c < 8; c++) ir_tab[id][c] = 0;
    endtask

    task automatic rand_tab(input int id);
        for (int c = 0; c < 8; c++) ir_tab[id][c] = int'($urandom_range(0, 4095));
    endtask

    // Start a sweep in the current cycle (cycle 0) and check every cycle.
    // restart_at / rst_at: cycle to raise IR_vld / rst again (-1 = never).
    // chains: number of times IR_vld is raised in DONE to chain a sweep.
    task automatic sweep(input int id, input int ncyc, input int restart_at,
                         input int rst_at, input int chains);
        int s_cyc, t_done, rel, cur, held, chains_left;
        s_cyc       = (id == 2) ? 0 : 2;
        t_done      = 8 * (s_cyc + 1) + 1;
        held        = held_err[id];
        cur         = model_err(id);
        chains_left = chains;
        rel         = 0;
        set_vld(id, 1'b1);
        for (int k = 1; k <= ncyc; k++) begin
            step();
            set_vld(id, 1'b0);
            rel++;
            if (rst_at >= 0 && k > rst_at) begin
                rst = 1'b0;
                chk($sformatf("rst_vld c%0d", k),  get_vld(id),  0);
                chk($sformatf("rst_busy c%0d", k), get_busy(id), 0);
                chk($sformatf("rst_sel c%0d", k),  get_sel(id),  0);
                chk($sformatf("rst_err c%0d", k),  get_err(id),  0);
            end else begin
                chk($sformatf("vld id%0d c%0d", id, k),  get_vld(id),  (rel == t_done) ? 1 : 0);
                chk($sformatf("busy id%0d c%0d", id, k), get_busy(id), (rel <= t_done) ? 1 : 0);
                if (rel < t_done)
                    chk($sformatf("sel id%0d c%0d", id, k), get_sel(id), (rel - 1) / (s_cyc + 1));
                else if (rel > t_done)
                    chk($sformatf("sel_idle id%0d c%0d", id, k), get_sel(id), 0);
                if (rel == t_done) begin
                    chk($sformatf("err id%0d c%0d", id, k), get_err(id), cur);
                    held = cur;
                end else begin
                    chk($sformatf("err_hold id%0d c%0d", id, k), get_err(id), held);
                end
                if (k == restart_at || (rel == t_done && chains_left > 0)) begin
                    if (rel == t_done) chains_left--;
                    rand_tab(id);
                    cur = model_err(id);
                    set_vld(id, 1'b1);
                    rel = 0;
                end
                if (k == rst_at) rst = 1'b1;
            end
        end
        held_err[id] = held;
        if (rst_at >= 0) begin
            for (int i = 0; i < 3; i++) held_err[i] = 0;
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            clear_tab(i);
            set_vld(i, 1'b0);
            held_err[i] = 0;
        end
        bus_a.ir_in = 12'd0;
        bus_b.ir_in = 12'd0;
        bus_c.ir_in = 12'd0;
        repeat (3) step();
        rst = 1'b0;

        // Reset then idle.
        for (int k = 0; k < 50; k++) begin
            step();
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("idle_vld id%0d", i),  get_vld(i),  0);
                chk($sformatf("idle_busy id%0d", i), get_busy(i), 0);
                chk($sformatf("idle_sel id%0d", i),  get_sel(i),  0);
                chk($sformatf("idle_err id%0d", i),  get_err(i),  0);
            end
        end

        // Balanced readings.
        for (int c = 0; c < 8; c++) ir_tab[0][c] = 32'h100;
        sweep(0, 30, -1, -1, 0);
        chk("balanced", get_err(0), 0);

        // Single channels.
        clear_tab(0); ir_tab[0][6] = 32'hFFF;
        sweep(0, 30, -1, -1, 0);
        chk("ch6", get_err(0), 32760);
        clear_tab(0); ir_tab[0][7] = 32'hFFF;
        sweep(0, 30, -1, -1, 0);
        chk("ch7", get_err(0), -32760);
        clear_tab(0); ir_tab[0][0] = 32'h123;
        sweep(0, 30, -1, -1, 0);
        chk("ch0", get_err(0), 32'h123);

        // Saturation with ERR_W=12.
        clear_tab(1); ir_tab[1][6] = 32'hFFF;
        sweep(1, 30, -1, -1, 0);
        chk("sat_hi", get_err(1), 2047);
        clear_tab(1); ir_tab[1][7] = 32'hFFF;
        sweep(1, 30, -1, -1, 0);
        chk("sat_lo", get_err(1), -2048);

        // Random sweeps, including saturating sums.
        for (int n = 0; n < 4; n++) begin
            rand_tab(0);
            sweep(0, 30, -1, -1, 0);
        end

        // Restart at cycle 10: pulse only at cycle 35.
        rand_tab(0);
        sweep(0, 40, 10, -1, 0);

        // Reset at cycle 12.
        rand_tab(0);
        sweep(0, 30, -1, 12, 0);

        // SETTLE_CYC=0: single sweep, then a chained pair.
        rand_tab(2);
        sweep(2, 15, -1, -1, 0);
        rand_tab(2);
        sweep(2, 25, -1, -1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
